// File: rtl/seg7_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_ctrl_pkg
// Brief  : Shared constants, anode table and digit helpers for the scan ctrl.
// Rev    : 1.0
// ============================================================================
package seg7_scan_ctrl_pkg;

  localparam int DEF_CLK_DIV = 50000;
  localparam int DEF_GUARD   = 16;

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Element 0 drives the rightmost digit.
  localparam logic [3:0][3:0] ANODE_TBL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  function automatic logic [3:0] nibble_of(input logic [15:0] v, input digit_e d);
    logic [3:0] n;
    case (d)
      DIG0:    n = v[3:0];
      DIG1:    n = v[7:4];
      DIG2:    n = v[11:8];
      default: n = v[15:12];
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_ctrl_if
// Brief  : Ready/enable write port carrying a new 16-bit display value.
// Rev    : 1.0
// ============================================================================
interface seg7_scan_ctrl_if;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        wr_ready;

  modport master (output wr_en, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl_seg7.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_ctrl_seg7
// Brief  : Registered hex-to-seven-segment decoder, active-low {g,f,e,d,c,b,a}.
// Rev    : 1.0
// ============================================================================
module seg7_scan_ctrl_seg7
  import seg7_scan_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] nib_i,
  input  logic       sinal_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_q;
  logic [6:0] seg_d;
  logic [6:0] w_hex;

  always_comb begin
    w_hex = SEG_BLANK;
    case (nib_i)
      4'h0: w_hex = 7'b1000000;
      4'h1: w_hex = 7'b1111001;
      4'h2: w_hex = 7'b0100100;
      4'h3: w_hex = 7'b0110000;
      4'h4: w_hex = 7'b0011001;
      4'h5: w_hex = 7'b0010010;
      4'h6: w_hex = 7'b0000010;
      4'h7: w_hex = 7'b1111000;
      4'h8: w_hex = 7'b0000000;
      4'h9: w_hex = 7'b0010000;
      4'hA: w_hex = 7'b0001000;
      4'hB: w_hex = 7'b0000011;
      4'hC: w_hex = 7'b1000110;
      4'hD: w_hex = 7'b0100001;
      4'hE: w_hex = 7'b0000110;
      default: w_hex = 7'b0001110;
    endcase
    seg_d = sinal_i ? SEG_MINUS : w_hex;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg_o = seg_q;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_ctrl
// Brief  : 4-digit multiplexed seven-segment scanner with tear-free updates.
// Rev    : 1.0
// ============================================================================
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int GUARD   = DEF_GUARD
) (
  input  logic                   clk,
  input  logic                   rst,
  seg7_scan_ctrl_if.slave        wr,
  input  logic                   signed_mode,
  input  logic                   blank_lz,
  output logic [6:0]             hex_out,
  output logic [3:0]             an_n,
  output logic                   frame_done,
  output logic                   ovf
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_e           idx_q, idx_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [3:0]       an_q, an_d;
  logic             fd_q, fd_d;

  logic             w_wrap;
  logic             w_neg;
  logic [15:0]      w_mag;
  logic [15:0]      w_show;
  logic [3:0]       w_nib;
  logic             w_minus;
  logic             w_upper_zero;
  logic             w_blank;

  always_comb begin
    w_wrap = (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d  = w_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d  = w_wrap ? digit_e'(idx_q + 2'd1) : idx_q;
    // Registered so the pulse coincides with the final count of digit 3.
    fd_d   = (idx_q == DIG3) && (cnt_q == CNT_W'(CLK_DIV - 2));

    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (fd_q && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end else if (wr.wr_en && !pend_v_q) begin
      pend_d   = wr.wr_data;
      pend_v_d = 1'b1;
    end
  end

  always_comb begin
    w_neg   = signed_mode & disp_q[15];
    w_mag   = disp_q[15] ? (~disp_q + 16'd1) : disp_q;
    w_show  = w_neg ? {4'h0, w_mag[11:0]} : disp_q;
    w_nib   = nibble_of(w_show, idx_q);
    w_minus = w_neg && (idx_q == DIG3);

    w_upper_zero = 1'b0;
    case (idx_q)
      DIG0:    w_upper_zero = 1'b0;
      DIG1:    w_upper_zero = (w_show[15:4] == 12'h000);
      DIG2:    w_upper_zero = (w_show[15:8] == 8'h00);
      default: w_upper_zero = (w_show[15:12] == 4'h0);
    endcase
    w_blank = blank_lz && !w_minus && w_upper_zero;

    an_d = ((cnt_q < CNT_W'(GUARD)) || w_blank) ? 4'b1111 : ANODE_TBL[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= DIG0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      an_q     <= 4'b1111;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  seg7_scan_ctrl_seg7 u_seg7 (
    .clk     (clk),
    .rst     (rst),
    .nib_i   (w_nib),
    .sinal_i (w_minus),
    .seg_o   (hex_out)
  );

  assign wr.wr_ready = !pend_v_q;
  assign an_n        = an_q;
  assign frame_done  = fd_q;
  assign ovf         = w_neg && (w_mag > 16'h0FFF);

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_seg7_scan_ctrl
// Brief  : Self-checking bench for seg7_scan_ctrl against a digit-level model.
// Rev    : 1.0
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int CD    = 4;
  localparam int GD    = 1;
  localparam int FRAME = 4 * CD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       signed_mode;
  logic       blank_lz;
  logic [6:0] hex_out;
  logic [3:0] an_n;
  logic       frame_done;
  logic       ovf;

  seg7_scan_ctrl_if wr_if ();

  seg7_scan_ctrl #(.CLK_DIV(CD), .GUARD(GD)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr_if.slave),
    .signed_mode (signed_mode),
    .blank_lz    (blank_lz),
    .hex_out     (hex_out),
    .an_n        (an_n),
    .frame_done  (frame_done),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          k;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pend_v;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  function automatic bit exp_ovf(input logic [15:0] v, input bit sm);
    int mag;
    if (!(sm && v[15])) return 1'b0;
    mag = 65536 - int'(v);
    return mag > 4095;
  endfunction

  // Expected segments and enable of digit d when value v is on display.
  function automatic void model_digit(input logic [15:0] v, input bit sm, input bit bl,
                                      input int d, output logic [6:0] seg, output bit en);
    bit neg;
    int mag;
    int shown;
    int msd;
    neg   = sm && v[15];
    mag   = neg ? 65536 - int'(v) : int'(v);
    shown = neg ? mag % 4096 : mag;
    msd   = 0;
    for (int i = 0; i < 4; i++)
      if (((shown >> (4 * i)) % 16) != 0) msd = i;
    if (neg && d == 3) begin
      seg = 7'b0111111;
      en  = 1'b1;
    end else begin
      seg = seg_tbl[(shown >> (4 * d)) % 16];
      en  = !bl || (d <= msd);
    end
  endfunction

  task automatic tick();
    bit          fr;
    logic [15:0] pdisp;
    bit          psm;
    bit          pbl;
    int          pk;
    int          d;
    int          c;
    logic [6:0]  eseg;
    bit          en;
    logic [3:0]  one;
    logic [3:0]  ean;
    fr    = (k % FRAME) == FRAME - 1;
    pdisp = m_disp;
    psm   = signed_mode;
    pbl   = blank_lz;
    pk    = k;
    if (fr && m_pend_v) begin
      m_disp   = m_pend;
      m_pend_v = 1'b0;
    end else if (wr_if.wr_en && !m_pend_v) begin
      m_pend   = wr_if.wr_data;
      m_pend_v = 1'b1;
    end
    @(posedge clk);
    #1;
    k++;
    d   = (pk / CD) % 4;
    c   = pk % CD;
    model_digit(pdisp, psm, pbl, d, eseg, en);
    one = 4'b0001;
    ean = (c < GD || !en) ? 4'b1111 : ~(one << d);
    chk("an_n", {12'h0, an_n}, {12'h0, ean});
    if (ean != 4'b1111) chk("hex_out", {9'h0, hex_out}, {9'h0, eseg});
    chk("frame_done", {15'h0, frame_done}, {15'h0, (k % FRAME) == FRAME - 1});
    chk("wr_ready", {15'h0, wr_if.wr_ready}, {15'h0, !m_pend_v});
    chk("ovf", {15'h0, ovf}, {15'h0, exp_ovf(m_disp, signed_mode)});
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < FRAME && (k % FRAME) != phase; i++) tick();
  endtask

  task automatic write(input logic [15:0] data);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_data = data;
    tick();
    wr_if.wr_en   = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst      = 1'b0;
    k        = 0;
    m_disp   = '0;
    m_pend   = '0;
    m_pend_v = 1'b0;
  endtask

  initial begin
    wr_if.wr_en   = 1'b0;
    wr_if.wr_data = '0;
    signed_mode   = 1'b0;
    blank_lz      = 1'b0;
    k             = 0;
    m_disp        = '0;
    m_pend        = '0;
    m_pend_v      = 1'b0;

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an_n", {12'h0, an_n}, 16'h000F);
    chk("rst_frame_done", {15'h0, frame_done}, 16'h0000);
    chk("rst_ovf", {15'h0, ovf}, 16'h0000);
    chk("rst_wr_ready", {15'h0, wr_if.wr_ready}, 16'h0001);
    release_reset();

    // Unsigned value, shown after the next frame boundary.
    write(16'h1234);
    run(2 * FRAME);

    // Second write while one is pending is dropped.
    run_to(5);
    write(16'hABCD);
    write(16'h5555);
    run(2 * FRAME);

    signed_mode = 1'b1;
    write(16'hFFFE);
    run(2 * FRAME);
    write(16'h8000);
    run(2 * FRAME);
    write(16'h0123);
    run(2 * FRAME);

    signed_mode = 1'b0;
    blank_lz    = 1'b1;
    write(16'h0007);
    run(2 * FRAME);
    write(16'h0000);
    run(2 * FRAME);
    write(16'h00A0);
    run(2 * FRAME);
    signed_mode = 1'b1;
    write(16'hFFF9);
    run(2 * FRAME);

    // Random traffic with mode inputs toggling mid-frame.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) signed_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) blank_lz = 1'($urandom_range(0, 1));
      wr_if.wr_en   = ($urandom_range(0, 2) == 0);
      wr_if.wr_data = 16'($urandom);
      if ($urandom_range(0, 1) == 0) wr_if.wr_data = wr_if.wr_data >> (4 * $urandom_range(1, 3));
      tick();
    end
    wr_if.wr_en = 1'b0;

    // Asynchronous reset during digit-2 dwell with a write pending.
    signed_mode = 1'b0;
    blank_lz    = 1'b0;
    run_to(0);
    run_to(8);
    write(16'h4321);
    run(2);
    rst = 1'b1;
    #1;
    chk("async_an_n", {12'h0, an_n}, 16'h000F);
    chk("async_wr_ready", {15'h0, wr_if.wr_ready}, 16'h0001);
    chk("async_frame_done", {15'h0, frame_done}, 16'h0000);
    repeat (2) @(posedge clk);
    release_reset();
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clock cycles per digit dwell (min 4).
REQ-002 SHALL have parameter GUARD, default 16, cycles at the start of each dwell with all anodes off (GUARD < CLK_DIV).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state rises on posedge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wr_en, input, 1, write request for a new display value.
REQ-006 SHALL have port wr_data, input, 16, value to display.
REQ-007 SHALL have port wr_ready, output, 1, high when a write is accepted this cycle.
REQ-008 SHALL have port signed_mode, input, 1, treat the shown value as two's complement.
REQ-009 SHALL have port blank_lz, input, 1, blank leading zero digits.
REQ-010 SHALL have port hex_out, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port an_n, output, 4, active-low digit enables; bit 0 is the rightmost digit.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse at the end of the digit-3 dwell.
REQ-013 SHALL have port ovf, output, 1, signed magnitude exceeds 0xFFF.

Function
REQ-014 Dwell counter SHALL count 0..CLK_DIV-1; digit index SHALL advance 0->1->2->3->0 when the counter wraps.
REQ-015 an_n SHALL be 4'b1111 for counter < GUARD and for blanked digits; otherwise it SHALL be the one-cold value of the digit index.
REQ-016 Digit nibble SHALL feed the seg7 decoder; an_n SHALL be delayed one cycle so it aligns with the registered hex_out.
REQ-017 Handshake: wr_ready = !pend_v; on wr_en && wr_ready, pend <= wr_data and pend_v <= 1.
REQ-018 On the cycle frame_done is asserted, if pend_v: disp <= pend, pend_v <= 0. The new value SHALL first show on the following digit-0 dwell (no tearing).
REQ-019 A write accepted in the same cycle as frame_done SHALL NOT be displayed until the next frame boundary.
REQ-020 wr_en while wr_ready=0 SHALL be ignored; the data is dropped and the pending value is unchanged.
REQ-021 Unsigned mode: digit k SHALL show disp[4k+3:4k] in hex.
REQ-022 Signed mode with disp[15]=1: digits 0-2 SHALL show |disp|[11:0]; digit 3 SHALL drive seg7 sinal=1 (minus, 7'b0111111).
REQ-023 Signed mode with disp[15]=0: digits show disp hex as in unsigned mode; ovf SHALL be 0.
REQ-024 ovf SHALL be 1 iff signed_mode and disp[15] and |disp| > 0xFFF; 0x8000 SHALL give magnitude 0x8000 and ovf=1.
REQ-025 blank_lz=1: every digit above the most significant nonzero digit SHALL be blanked. Digit 0 is never blanked. A minus digit is never blanked.
REQ-026 signed_mode and blank_lz SHALL be sampled combinationally each cycle; mid-frame changes take effect on the next dwell.

Reset
REQ-027 On rst: counter=0, index=0, disp=0, pend=0, pend_v=0, an_n=4'b1111, frame_done=0, ovf=0. wr_ready SHALL be 1 one cycle after rst deasserts.
REQ-028 rst asserted mid-frame SHALL drop any pending value and force an_n=4'b1111 immediately, asynchronously.

Structure
REQ-029 A shared package SHALL hold the 4-entry one-cold anode table, the SEG_MINUS and SEG_BLANK constants, and the default CLK_DIV/GUARD values.
REQ-030 One sub-module: the existing seg7 decoder, instantiated once, with clk/rst passed through and sinal driven per REQ-022.

Verification (CLK_DIV=4, GUARD=1)
REQ-031 Reset, then write 0x1234 -> after the next frame_done, digits 0..3 show 4,3,2,1 (hex_out 0011001, 0110000, 0100100, 1111001); an_n cycles 1110, 1101, 1011, 0111.
REQ-032 Write 0xABCD mid-frame, then a second write 0x5555 before the boundary -> the second write is rejected (wr_ready=0); 0xABCD shows only from the next digit-0 dwell.
REQ-033 signed_mode=1, write 0xFFFE -> digits 0..3 show 2,0,0,minus; ovf=0.
REQ-034 signed_mode=1, write 0x8000 -> ovf=1; digit 3 shows minus.
REQ-035 blank_lz=1, write 0x0007 -> only digit 0 is enabled (an_n=1110 in its dwell, 1111 otherwise); write 0x0000 -> digit 0 shows 1000000.
REQ-036 Assert rst during the digit-2 dwell with pend_v=1 -> an_n=1111 at once; after release, the display shows 0 and wr_ready=1.
